// File: rtl/sync_clkgen_pkg.sv
// Shared types and helpers for the multi-channel divided clock generator.
package sync_clkgen_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        BURST = 2'd2,
        DRAIN = 2'd3
    } ch_state_t;

    localparam int MIN_DIV = 2;

    // Factors below MIN_DIV cannot produce both a high and a low phase.
    function automatic logic [31:0] clamp_div(input logic [31:0] d);
        return (d < 32'(MIN_DIV)) ? 32'(MIN_DIV) : d;
    endfunction

endpackage

// File: rtl/sync_clkgen_ch.sv
// One divided-clock channel: state machine, phase counter, pending divider
// and burst pulse counter; all outputs are registered.
module sync_clkgen_ch
    import sync_clkgen_pkg::*;
#(
    parameter int DIV_W       = 16,
    parameter int CNT_W       = 16,
    parameter int DEFAULT_DIV = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cfg_we,
    input  logic [DIV_W-1:0] cfg_div,
    input  logic             ch_en,
    input  logic             burst_start,
    input  logic [CNT_W-1:0] burst_len,
    output logic             o_clk,
    output logic             o_rise,
    output logic             o_fall,
    output logic             busy,
    output logic             burst_done
);

    ch_state_t        state_reg, state_next;
    logic [DIV_W-1:0] cnt_reg, cnt_next;
    logic [DIV_W-1:0] div_reg, div_next;
    logic [DIV_W-1:0] pend_reg, pend_next;
    logic             pend_flag_reg, pend_flag_next;
    logic [CNT_W-1:0] rem_reg, rem_next;
    logic             clk_reg, clk_next;
    logic             rise_reg, rise_next;
    logic             fall_reg, fall_next;
    logic             busy_reg, busy_next;
    logic             done_reg, done_next;

    logic [DIV_W-1:0] div_new;
    logic [DIV_W-1:0] half_next;
    logic             wrap;
    logic             active_next;

    assign div_new = DIV_W'(clamp_div(32'(cfg_div)));
    assign wrap    = (cnt_reg == (div_reg - DIV_W'(1)));

    always_comb begin
        state_next     = state_reg;
        cnt_next       = cnt_reg;
        div_next       = div_reg;
        pend_next      = pend_reg;
        pend_flag_next = pend_flag_reg;
        rem_next       = rem_reg;
        done_next      = 1'b0;

        if (state_reg == IDLE) begin
            cnt_next       = '0;
            pend_flag_next = 1'b0;
            // A write that landed on the final boundary of the last run
            // is still waiting in the pending register.
            if (cfg_we) begin
                div_next = div_new;
            end else if (pend_flag_reg) begin
                div_next = pend_reg;
            end
            if (burst_start) begin
                if (burst_len != '0) begin
                    state_next = BURST;
                    rem_next   = burst_len;
                end else begin
                    done_next = 1'b1;
                end
            end else if (ch_en) begin
                state_next = RUN;
            end
        end else begin
            // The pending factor swaps in only at a period boundary; a write
            // on the boundary itself waits for the following one.
            if (cfg_we) begin
                pend_next      = div_new;
                pend_flag_next = 1'b1;
            end else if (wrap) begin
                pend_flag_next = 1'b0;
            end
            if (wrap) begin
                cnt_next = '0;
                if (pend_flag_reg) begin
                    div_next = pend_reg;
                end
            end else begin
                cnt_next = cnt_reg + DIV_W'(1);
            end

            case (state_reg)
                RUN: begin
                    if (!ch_en) begin
                        state_next = wrap ? IDLE : DRAIN;
                    end
                end
                DRAIN: begin
                    if (ch_en) begin
                        state_next = RUN;
                    end else if (wrap) begin
                        state_next = IDLE;
                    end
                end
                BURST: begin
                    if (wrap) begin
                        rem_next = (rem_reg != '0) ? (rem_reg - CNT_W'(1)) : '0;
                        if (rem_reg <= CNT_W'(1)) begin
                            state_next = IDLE;
                            done_next  = 1'b1;
                        end
                    end
                end
                default: begin
                    state_next = IDLE;
                end
            endcase
        end

        if (state_next == IDLE) begin
            cnt_next = '0;
        end
    end

    // Outputs are derived from the next phase so they line up with cnt_reg.
    assign active_next = (state_next != IDLE);
    assign half_next   = div_next >> 1;

    always_comb begin
        clk_next  = active_next && (cnt_next < half_next);
        rise_next = active_next && (cnt_next == '0);
        fall_next = active_next && (cnt_next == half_next);
        busy_next = active_next;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg     <= IDLE;
            cnt_reg       <= '0;
            div_reg       <= DIV_W'(DEFAULT_DIV);
            pend_reg      <= DIV_W'(DEFAULT_DIV);
            pend_flag_reg <= 1'b0;
            rem_reg       <= '0;
            clk_reg       <= 1'b0;
            rise_reg      <= 1'b0;
            fall_reg      <= 1'b0;
            busy_reg      <= 1'b0;
            done_reg      <= 1'b0;
        end else begin
            state_reg     <= state_next;
            cnt_reg       <= cnt_next;
            div_reg       <= div_next;
            pend_reg      <= pend_next;
            pend_flag_reg <= pend_flag_next;
            rem_reg       <= rem_next;
            clk_reg       <= clk_next;
            rise_reg      <= rise_next;
            fall_reg      <= fall_next;
            busy_reg      <= busy_next;
            done_reg      <= done_next;
        end
    end

    assign o_clk      = clk_reg;
    assign o_rise     = rise_reg;
    assign o_fall     = fall_reg;
    assign busy       = busy_reg;
    assign burst_done = done_reg;

endmodule

// File: rtl/sync_clkgen_multi.sv
// NUM_CH independent divided-clock channels sharing one configuration bus.
module sync_clkgen_multi
    import sync_clkgen_pkg::*;
#(
    parameter int NUM_CH      = 2,
    parameter int DIV_W       = 16,
    parameter int CNT_W       = 16,
    parameter int DEFAULT_DIV = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NUM_CH-1:0] cfg_we,
    input  logic [DIV_W-1:0]  cfg_div,
    input  logic [NUM_CH-1:0] ch_en,
    input  logic [NUM_CH-1:0] burst_start,
    input  logic [CNT_W-1:0]  burst_len,
    output logic [NUM_CH-1:0] o_clk,
    output logic [NUM_CH-1:0] o_rise,
    output logic [NUM_CH-1:0] o_fall,
    output logic [NUM_CH-1:0] busy,
    output logic [NUM_CH-1:0] burst_done
);

    generate
        for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
            sync_clkgen_ch #(
                .DIV_W      (DIV_W),
                .CNT_W      (CNT_W),
                .DEFAULT_DIV(DEFAULT_DIV)
            ) u_ch (
                .clk        (clk),
                .rst        (rst),
                .cfg_we     (cfg_we[gi]),
                .cfg_div    (cfg_div),
                .ch_en      (ch_en[gi]),
                .burst_start(burst_start[gi]),
                .burst_len  (burst_len),
                .o_clk      (o_clk[gi]),
                .o_rise     (o_rise[gi]),
                .o_fall     (o_fall[gi]),
                .busy       (busy[gi]),
                .burst_done (burst_done[gi])
            );
        end
    endgenerate

endmodule

// File: tb/tb_sync_clkgen_multi.sv
// Directed bench for sync_clkgen_multi with hand-derived waveforms.
module tb_sync_clkgen_multi;

    localparam int NUM_CH = 2;
    localparam int DIV_W  = 16;
    localparam int CNT_W  = 16;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic [NUM_CH-1:0] cfg_we = '0;
    logic [DIV_W-1:0]  cfg_div = '0;
    logic [NUM_CH-1:0] ch_en = '0;
    logic [NUM_CH-1:0] burst_start = '0;
    logic [CNT_W-1:0]  burst_len = '0;
    logic [NUM_CH-1:0] o_clk, o_rise, o_fall, busy, burst_done;

    int checks   = 0;
    int failures = 0;

    sync_clkgen_multi #(
        .NUM_CH(NUM_CH), .DIV_W(DIV_W), .CNT_W(CNT_W), .DEFAULT_DIV(8)
    ) dut (
        .clk(clk), .rst(rst), .cfg_we(cfg_we), .cfg_div(cfg_div),
        .ch_en(ch_en), .burst_start(burst_start), .burst_len(burst_len),
        .o_clk(o_clk), .o_rise(o_rise), .o_fall(o_fall),
        .busy(busy), .burst_done(burst_done)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
        $display("check %0d %s observed=%0h expected=%0h", checks, tag, obs, exp);
    endtask

    task automatic write_div(input logic [NUM_CH-1:0] we, input int d);
        cfg_we  = we;
        cfg_div = DIV_W'(d);
        tick();
        cfg_we  = '0;
    endtask

    initial begin
        int rises;
        logic [9:0] pat_clk;
        logic [9:0] pat_rise;
        logic [5:0] pat6;

        // 1: reset, then D=4 free run
        tick(); tick();
        chk("rst_oclk", 32'(o_clk), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_rise_fall", 32'({o_rise, o_fall}), 0);
        chk("rst_done", 32'(burst_done), 0);
        rst = 1'b0;
        write_div(2'b01, 4);
        chk("idle_after_cfg", 32'({o_clk[0], busy[0]}), 0);
        ch_en = 2'b01;
        for (int i = 0; i < 12; i++) begin
            tick();
            chk($sformatf("d4_clk_%0d", i), 32'(o_clk[0]), 32'((i % 4) < 2));
            chk($sformatf("d4_rise_%0d", i), 32'(o_rise[0]), 32'((i % 4) == 0));
            chk($sformatf("d4_fall_%0d", i), 32'(o_fall[0]), 32'((i % 4) == 2));
            chk($sformatf("d4_busy_%0d", i), 32'(busy[0]), 1);
        end
        chk("ch1_quiet", 32'({o_clk[1], busy[1]}), 0);
        ch_en = 2'b00;
        tick();
        chk("d4_stop_busy", 32'(busy[0]), 0);
        chk("d4_stop_clk", 32'(o_clk[0]), 0);

        // 2: D=5, stop during high phase
        write_div(2'b01, 5);
        ch_en = 2'b01;
        for (int i = 0; i < 11; i++) begin
            tick();
            chk($sformatf("d5_clk_%0d", i), 32'(o_clk[0]), 32'((i % 5) < 2));
        end
        ch_en = 2'b00;
        tick();
        chk("d5_drain_high", 32'({o_clk[0], busy[0]}), 32'b11);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk($sformatf("d5_drain_low_%0d", i), 32'({o_clk[0], busy[0], o_rise[0]}), 32'b010);
        end
        tick();
        chk("d5_drain_idle", 32'({o_clk[0], busy[0], o_rise[0]}), 0);
        tick();
        chk("d5_no_extra_rise", 32'({o_clk[0], o_rise[0]}), 0);

        // 3: D=4 burst of 3, mid-burst restart ignored
        write_div(2'b01, 4);
        burst_len   = 16'd3;
        burst_start = 2'b01;
        tick();
        burst_start = 2'b00;
        rises = 0;
        for (int i = 0; i < 12; i++) begin
            if (i > 0) tick();
            if (i == 5) begin
                burst_len   = 16'd5;
                burst_start = 2'b01;
            end
            if (i == 6) burst_start = 2'b00;
            if (o_rise[0]) rises++;
            chk($sformatf("burst_clk_%0d", i), 32'(o_clk[0]), 32'((i % 4) < 2));
            chk($sformatf("burst_busy_done_%0d", i), 32'({busy[0], burst_done[0]}), 32'b10);
        end
        burst_start = 2'b00;
        chk("burst_rise_count", 32'(rises), 3);
        tick();
        chk("burst_done_pulse", 32'({burst_done[0], busy[0], o_clk[0]}), 32'b100);
        tick();
        chk("burst_done_once", 32'({burst_done[0], busy[0], o_clk[0]}), 0);

        // 4: retune 4 -> 6 mid-period, then 0 (clamped to 2) on a boundary
        ch_en = 2'b01;
        tick();
        chk("rt_cnt0", 32'(o_clk[0]), 1);
        tick();
        chk("rt_cnt1", 32'(o_clk[0]), 1);
        write_div(2'b01, 6);
        chk("rt_cnt2", 32'(o_clk[0]), 0);
        tick();
        chk("rt_cnt3", 32'({o_clk[0], o_rise[0]}), 0);
        pat6 = 6'b000111;
        for (int i = 0; i < 6; i++) begin
            tick();
            chk($sformatf("rt_d6_%0d", i), 32'(o_clk[0]), 32'(pat6[i]));
        end
        cfg_we  = 2'b01;
        cfg_div = 16'd0;
        pat_clk  = 10'b0101000111;
        pat_rise = 10'b0101000001;
        for (int i = 0; i < 10; i++) begin
            tick();
            cfg_we = '0;
            chk($sformatf("rt_mix_clk_%0d", i), 32'(o_clk[0]), 32'(pat_clk[i]));
            chk($sformatf("rt_mix_rise_%0d", i), 32'(o_rise[0]), 32'(pat_rise[i]));
        end
        chk("rt_d2_fall", 32'(o_fall[0]), 1);
        ch_en = 2'b00;
        tick();
        chk("rt_stop", 32'({busy[0], o_clk[0]}), 0);

        // 5: zero-length burst; burst with ch_en held high (D=2)
        burst_len   = 16'd0;
        burst_start = 2'b01;
        tick();
        burst_start = 2'b00;
        chk("b0_done", 32'({burst_done[0], busy[0], o_clk[0]}), 32'b100);
        tick();
        chk("b0_done_once", 32'({burst_done[0], busy[0], o_clk[0]}), 0);
        burst_len   = 16'd2;
        burst_start = 2'b01;
        ch_en       = 2'b01;
        tick();
        burst_start = 2'b00;
        for (int i = 0; i < 4; i++) begin
            if (i > 0) tick();
            chk($sformatf("bc_clk_%0d", i), 32'({o_clk[0], busy[0], burst_done[0]}),
                32'({((i % 2) == 0), 1'b1, 1'b0}));
        end
        tick();
        chk("bc_done", 32'({o_clk[0], busy[0], burst_done[0]}), 32'b001);
        tick();
        chk("bc_to_run", 32'({o_clk[0], o_rise[0], busy[0], burst_done[0]}), 32'b1110);
        ch_en = 2'b00;
        tick();
        chk("bc_drain", 32'({o_clk[0], busy[0]}), 32'b01);
        tick();
        chk("bc_idle", 32'(busy[0]), 0);

        // 6: two aligned D=8 channels, then reset mid-burst
        write_div(2'b11, 8);
        ch_en = 2'b11;
        for (int i = 0; i < 16; i++) begin
            tick();
            chk($sformatf("al_clk_%0d", i), 32'(o_clk), 32'({2{(i % 8) < 4}}));
        end
        ch_en = 2'b00;
        tick();
        chk("al_stop", 32'(busy), 0);
        write_div(2'b01, 3);
        burst_len   = 16'd5;
        burst_start = 2'b10;
        tick();
        burst_start = 2'b00;
        write_div(2'b10, 6);
        tick();
        chk("mid_burst_busy", 32'(busy), 32'b10);
        rst = 1'b1;
        tick();
        chk("rst_mid_outs", 32'({o_clk, o_rise, o_fall, busy, burst_done}), 0);
        rst = 1'b0;
        ch_en = 2'b11;
        for (int i = 0; i < 8; i++) begin
            tick();
            chk($sformatf("post_rst_clk_%0d", i), 32'(o_clk), 32'({2{i < 4}}));
        end
        ch_en = 2'b00;
        tick();
        chk("final_idle", 32'(busy), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
